// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: datapath width, NOP encoding and the
// {instr, pc} entry held in the instruction queue.
package fetch_unit_pkg;
    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if import fetch_unit_pkg::*; #(parameter int AW = XLEN);
    logic               req_valid;
    logic               req_ready;
    logic [AW-1:0]      req_addr;
    logic               rsp_valid;
    logic [INSTR_W-1:0] rsp_data;

    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with fall-through head (rdata shows the oldest entry as soon
// as it is written); flush empties it in one cycle.
module fetch_queue #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = do_pop  ? nxt(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? nxt(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));
endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues in-order fetches under a credit limit, buffers
// responses for IF/ID and discards responses to requests made before a redirect.
module fetch_unit import fetch_unit_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_unit_if.master       imem,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               stall,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [XLEN-1:0]    if_id_pc,
    output logic [XLEN-1:0]    if_id_pc4
);
    localparam int CW = $clog2(FQ_DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
    logic            run_q;
    logic [CW-1:0]   iq_count, aq_count;
    logic            iq_full, iq_empty, aq_full, aq_empty;
    fetch_entry_t    iq_wdata, iq_head;
    logic [XLEN-1:0] aq_head;
    logic            accept, rsp_live, iq_push, iq_pop;

    always_comb begin
        imem.req_valid = run_q && !redirect_valid &&
                         (({1'b0, outstanding_q} + {1'b0, iq_count}) < (CW + 1)'(FQ_DEPTH));
        imem.req_addr  = pc_q;
        accept         = imem.req_valid && imem.req_ready;
        // A response with nothing outstanding belongs to a request lost to reset.
        rsp_live       = imem.rsp_valid && (outstanding_q != '0);
        iq_push        = rsp_live && (drop_cnt_q == '0) && !redirect_valid;
        iq_wdata       = '{instr: imem.rsp_data, pc: aq_head};
        iq_pop         = !iq_empty && !stall && !redirect_valid;
        outstanding_d  = outstanding_q + CW'(accept) - CW'(rsp_live);
        if (redirect_valid) begin
            pc_d       = redirect_pc & ~XLEN'(3);
            // Everything still in flight after this edge predates the redirect.
            drop_cnt_d = outstanding_q - CW'(rsp_live);
        end else begin
            pc_d       = accept ? pc_q + XLEN'(4) : pc_q;
            drop_cnt_d = drop_cnt_q - CW'(rsp_live && (drop_cnt_q != '0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            run_q         <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            run_q         <= 1'b1;
        end
    end

    fetch_queue #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FQ_DEPTH)) u_instr_q (
        .clk, .rst_n, .push(iq_push), .pop(iq_pop), .flush(redirect_valid),
        .wdata(iq_wdata), .rdata(iq_head), .full(iq_full), .empty(iq_empty), .count(iq_count)
    );

    fetch_queue #(.WIDTH(XLEN), .DEPTH(FQ_DEPTH)) u_addr_q (
        .clk, .rst_n, .push(accept), .pop(rsp_live), .flush(1'b0),
        .wdata(pc_q), .rdata(aq_head), .full(aq_full), .empty(aq_empty), .count(aq_count)
    );

    always_comb begin
        if_id_valid = !iq_empty;
        if_id_instr = if_id_valid ? iq_head.instr : NOP_INSTR;
        if_id_pc    = if_id_valid ? iq_head.pc : '0;
        if_id_pc4   = if_id_pc + XLEN'(4);
    end

    a_addr_track: assert property (@(posedge clk) disable iff (!rst_n)
        (aq_count == outstanding_q) && !(accept && aq_full) && !(rsp_live && aq_empty));
    a_credit: assert property (@(posedge clk) disable iff (!rst_n)
        !(iq_full && imem.req_valid) && (drop_cnt_q <= outstanding_q));
endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: an in-order memory model with variable latency
// and a scoreboard of the PCs the program should deliver to IF/ID.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, redirect_valid, stall;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc4;

    fetch_unit_if #(.AW(32)) imem ();

    fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem(imem.master),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       mq[$];
    logic [31:0] sb[$];
    logic [31:0] exp_next, e, prev_addr, prev_pc, prev_instr;
    int          cyc = 0, tests = 0, fails = 0;
    int          lat_lo = 1, lat_hi = 1, rdy_mode = 0, d, first_acc = -1;
    logic        check_lat1 = 1'b0, prev_redir = 1'b0, prev_hold = 1'b0, prev_stall = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory: serves the oldest request once its latency has elapsed, one per cycle.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem.rsp_valid = 1'b1;
            imem.rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem.rsp_valid = 1'b0;
            imem.rsp_data  = $urandom;
        end
        case (rdy_mode)
            0:       imem.req_ready = 1'b1;
            1:       imem.req_ready = 1'b0;
            default: imem.req_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: everything sampled at the falling edge describes the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_req_valid", imem.req_valid == 1'b0, 32'(imem.req_valid), 0);
            chk("reset_if_id_valid", if_id_valid == 1'b0, 32'(if_id_valid), 0);
            chk("reset_instr", if_id_instr == NOP, if_id_instr, NOP);
            chk("reset_pc", if_id_pc == 32'h0, if_id_pc, 0);
            chk("reset_pc4", if_id_pc4 == 32'h4, if_id_pc4, 4);
            sb.delete();
            exp_next   = RESET_PC;
            first_acc  = -1;
            prev_redir = 1'b0; prev_hold = 1'b0; prev_stall = 1'b0;
            if (imem.rsp_valid && mq.size() > 0) void'(mq.pop_front());
        end else begin
            if (prev_redir) chk("flushed_after_redirect", !if_id_valid, 32'(if_id_valid), 0);
            if (prev_hold && !redirect_valid) begin
                chk("req_valid_held", imem.req_valid, 32'(imem.req_valid), 1);
                chk("req_addr_held", imem.req_addr == prev_addr, imem.req_addr, prev_addr);
            end
            if (prev_stall) begin
                chk("stall_head_pc", if_id_valid && if_id_pc == prev_pc, if_id_pc, prev_pc);
                chk("stall_head_instr", if_id_instr == prev_instr, if_id_instr, prev_instr);
            end
            if (!if_id_valid) chk("invalid_is_nop", if_id_instr == NOP, if_id_instr, NOP);
            if (check_lat1 && first_acc >= 0 && cyc == first_acc + 2) begin
                chk("lat1_valid", if_id_valid, 32'(if_id_valid), 1);
                chk("lat1_pc", if_id_pc == RESET_PC, if_id_pc, RESET_PC);
                chk("lat1_pc4", if_id_pc4 == RESET_PC + 4, if_id_pc4, RESET_PC + 4);
            end
            if (redirect_valid) chk("no_issue_on_redirect", !imem.req_valid, 32'(imem.req_valid), 0);
            if (if_id_valid && !stall && !redirect_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_instr", 1'b0, if_id_pc, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("pop_pc", if_id_pc == e, if_id_pc, e);
                    chk("pop_instr", if_id_instr == mem_word(e), if_id_instr, mem_word(e));
                    chk("pop_pc4", if_id_pc4 == e + 4, if_id_pc4, e + 4);
                end
            end
            if (imem.req_valid && imem.req_ready) begin
                chk("req_addr", imem.req_addr == exp_next, imem.req_addr, exp_next);
                d = cyc + $urandom_range(lat_lo, lat_hi);
                if (mq.size() > 0 && d < mq[$].due) d = mq[$].due;
                mq.push_back('{addr: imem.req_addr, due: d});
                sb.push_back(exp_next);
                exp_next += 4;
                if (first_acc < 0) first_acc = cyc;
                chk("credit_limit", sb.size() <= 2, 32'(sb.size()), 2);
            end
            if (imem.rsp_valid && mq.size() > 0) void'(mq.pop_front());
            if (redirect_valid) begin
                sb.delete();
                exp_next = redirect_pc & ~32'h3;
            end
            prev_redir = redirect_valid;
            prev_hold  = imem.req_valid && !imem.req_ready && !redirect_valid;
            prev_stall = if_id_valid && stall && !redirect_valid;
            prev_addr  = imem.req_addr;
            prev_pc    = if_id_pc;
            prev_instr = if_id_instr;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
            redirect_valid = 1'b0;
        end
    endtask

    task automatic redirect(input logic [31:0] t);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = t;
        step();
    endtask

    task automatic wait_mq(input int want, input string name);
        int n = 0;
        while (mq.size() != want && n < 40) begin step(); n++; end
        chk(name, mq.size() == want, 32'(mq.size()), 32'(want));
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem.rsp_valid = 1'b0; imem.rsp_data = '0; imem.req_ready = 1'b1;
        step(3);
        rst_n = 1'b1;
        check_lat1 = 1'b1;
        step(12);
        check_lat1 = 1'b0;
        stall = 1'b1; step(5);
        stall = 1'b0; step(10);
        lat_lo = 3; lat_hi = 3;
        wait_mq(2, "two_outstanding");
        redirect(32'h100); step(15);
        redirect(32'h202); step(10);
        lat_lo = 1; lat_hi = 1;
        stall = 1'b1; step(6);
        redirect(32'h300); stall = 1'b0; step(8);
        lat_lo = 2; lat_hi = 2; step(4);
        begin
            int n = 0;
            while (!imem.rsp_valid && n < 40) begin step(); n++; end
            chk("rsp_for_redirect", imem.rsp_valid, 32'(imem.rsp_valid), 1);
            redirect_valid = 1'b1; redirect_pc = 32'h400;
            step(10);
        end
        lat_lo = 3; lat_hi = 3; step(3);
        wait_mq(1, "one_outstanding");
        rst_n = 1'b0; rdy_mode = 1; step(2);
        rst_n = 1'b1;
        wait_mq(0, "stale_drain");
        step(2);
        chk("stale_not_pushed", !if_id_valid, 32'(if_id_valid), 0);
        rdy_mode = 0; lat_lo = 1; lat_hi = 3; step(15);
        rdy_mode = 1; step(5);
        rdy_mode = 0; step(10);
        rdy_mode = 2; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
            @(posedge clk);
            #2;
            redirect_valid = 1'b0;
        end
        stall = 1'b0; rdy_mode = 0; step(20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
